// File: rtl/serial_sum_collector_pkg.sv
// Shared definitions for the bit-serial adder collector stage: FSM state
// encodings and the default word width. These encodings are also used by
// the adder's input shift registers, so keep the values fixed.
package serial_sum_collector_pkg;

    // Default operand/result width of the serial adder.
    localparam int DEFAULT_WIDTH = 4;

    // Collector FSM states. The encodings are fixed so that other blocks can
    // decode them directly.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage : serial_sum_collector_pkg

// File: rtl/serial_sum_collector_sipo_shift_reg.sv
// Serial-in/parallel-out shift register. Bits enter at the MSB and move
// toward the LSB, so after WIDTH shifts of an LSB-first stream the register
// holds the word in natural bit order. clr has priority over shift_en.
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    // Shift register: clear on request, otherwise shift in one bit per enable.
    // NOTE: this is a small flop register rather than a RAM, so it takes the
    // async reset like any other control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            // NOTE: non-blocking assignments here so every flop updates from
            // the pre-edge values; blocking would create order-dependent races.
            q <= '0;
        end else if (shift_en) begin
            q <= {bit_in, q[WIDTH-1:1]};
        end
    end

endmodule : sipo_shift_reg

// File: rtl/serial_sum_collector.sv
// Collector stage of the bit-serial adder. Assembles WIDTH LSB-first sum bits
// into a parallel word, captures the adder's final carry with the last bit,
// and offers the result on a valid/ready handshake. Bits or start requests
// that arrive while a result is still pending are dropped and flagged with a
// one-cycle overrun pulse (registered, so it appears the cycle after the drop).
module serial_sum_collector
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    // Bit counter only needs to reach WIDTH-1; it returns to 0 on the last bit.
    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sh_clr;
    logic             sh_en;
    logic             load_result;
    logic             overrun_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_full;
    logic             unused_shreg_lsb;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sh_clr),
        .shift_en (sh_en),
        .bit_in   (bit_in),
        .q        (shreg)
    );

    // The completed word is the shift register as it will look after the
    // final shift; capturing it directly keeps out_valid one cycle after the
    // last bit instead of two. The outgoing LSB is shifted out and not needed.
    assign word_full        = {bit_in, shreg[WIDTH-1:1]};
    assign unused_shreg_lsb = shreg[0];

    // Next-state, counter and datapath control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt   = state;
        cnt_nxt     = cnt;
        sh_clr      = 1'b0;
        sh_en       = 1'b0;
        load_result = 1'b0;
        overrun_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                // Stray bits before a start are ignored silently.
                if (start) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = '0;
                    sh_clr    = 1'b1;
                end
            end

            COLLECT: begin
                if (start) begin
                    // Abort the partial word; a same-cycle bit is discarded.
                    cnt_nxt = '0;
                    sh_clr  = 1'b1;
                end else if (bit_valid) begin
                    sh_en = 1'b1;
                    if (cnt == LAST_CNT) begin
                        load_result = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = HOLD;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    // Transfer completes; a same-cycle start chains the next word.
                    if (start) begin
                        state_nxt = COLLECT;
                        cnt_nxt   = '0;
                        sh_clr    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                // Any bit in HOLD is lost, and so is a start that cannot be
                // honoured; both together still give a single pulse.
                overrun_nxt = bit_valid | (start & ~out_ready);
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, bit counter and overrun pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            overrun <= overrun_nxt;
        end
    end

    // Result register: loaded only on the last bit, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (load_result) begin
            sum_out   <= word_full;
            carry_out <= carry_in;
        end
    end

    // Status outputs decode straight from the state register, so they are
    // glitch-free and change only on clock edges or reset.
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule : serial_sum_collector
